// File: rtl/alu_wide_seq_pkg.sv
// rtl/alu_wide_seq_pkg.sv - opcode classes, FSM states and slice opcode helper for alu_wide_seq
package alu_wide_seq_pkg;

   localparam logic [1:0] OPC_ADDSUB   = 2'b00;
   localparam logic [1:0] OPC_BIT      = 2'b01;
   localparam logic [1:0] OPC_SHL      = 2'b10;
   localparam logic [1:0] OPC_SHR      = 2'b11;
   localparam int         OP_CARRY_BIT = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Upper add/sub slices must consume the incoming carry/borrow, so force the carry-use bit.
   function automatic logic [3:0] slice_op(input logic [3:0] op, input logic first);
      logic [3:0] r;
      r = op;
      if ((op[3:2] == OPC_ADDSUB) && !first) begin
         r[OP_CARRY_BIT] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// rtl/alu_wide_seq_if.sv - issue/result bus of alu_wide_seq; zero flag present with ALU_WIDE_SEQ_ZERO_EN
interface alu_wide_seq_if #(parameter int NBYTES = 4);

   localparam int W = 8 * NBYTES;

   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] q;
   logic         cout;
`ifdef ALU_WIDE_SEQ_ZERO_EN
   logic         zero;

   modport master (output start, op, a, b, cin, input busy, done, q, cout, zero);
   modport slave  (input start, op, a, b, cin, output busy, done, q, cout, zero);
`else
   modport master (output start, op, a, b, cin, input busy, done, q, cout);
   modport slave  (input start, op, a, b, cin, output busy, done, q, cout);
`endif

endinterface

// File: rtl/alu_wide_seq_byte_slice_sel.sv
// rtl/alu_wide_seq_byte_slice_sel.sv - selects one byte of a wide word by slice index
module byte_slice_sel #(
   parameter int NBYTES = 4,
   parameter int IW     = 2
) (
   input  logic [8*NBYTES-1:0] word,
   input  logic [IW-1:0]       idx,
   output logic [7:0]          slice
);

   // Plain mux over byte lanes; out-of-range indices read as zero.
   always_comb begin
      slice = 8'h00;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx == IW'(k)) begin
            slice = word[k*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/alu_wide_seq.sv
// rtl/alu_wide_seq.sv - byte-serial sequencer for an external 8-bit alu; ALU_WIDE_SEQ_ZERO_EN adds zero flag
module alu_wide_seq
   import alu_wide_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_wide_seq_if.slave        bus,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_op,
   output logic                 alu_cin,
   input  logic [7:0]           alu_q,
   input  logic                 alu_cout
);

   localparam int            W        = 8 * NBYTES;
   localparam int            IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

   state_t        state, state_n;
   logic [W-1:0]  a_r, b_r, q_r;
   logic [3:0]    op_r;
   logic          cin_r, carry_r, cout_r;
   logic [IW-1:0] idx;
   logic [7:0]    a_slice, b_slice;
   logic          shr_dir, first, last;

   // Right shifts walk MSB->LSB so each slice's shifted-out bit feeds the next lower byte.
   assign shr_dir = (op_r[3:2] == OPC_SHR);
   assign first   = shr_dir ? (idx == IDX_LAST) : (idx == '0);
   assign last    = shr_dir ? (idx == '0) : (idx == IDX_LAST);

   byte_slice_sel #(.NBYTES(NBYTES), .IW(IW)) u_sel_a (.word(a_r), .idx(idx), .slice(a_slice));
   byte_slice_sel #(.NBYTES(NBYTES), .IW(IW)) u_sel_b (.word(b_r), .idx(idx), .slice(b_slice));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next state and alu slice drive; alu inputs are zero outside RUN.
   always_comb begin
      state_n = state;
      alu_a   = 8'h00;
      alu_b   = 8'h00;
      alu_op  = 4'h0;
      alu_cin = 1'b0;
      case (state)
         S_IDLE: if (bus.start) state_n = S_RUN;
         S_RUN: begin
            alu_a   = a_slice;
            alu_b   = b_slice;
            alu_op  = slice_op(op_r, first);
            alu_cin = first ? cin_r : carry_r;
            if (last) state_n = S_DONE;
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = (state == S_DONE);
   assign bus.q    = q_r;
   assign bus.cout = cout_r;

`ifdef ALU_WIDE_SEQ_ZERO_EN
   logic nz_r, zero_r;
   assign bus.zero = zero_r;

   // Running OR of slice results; zero is committed on the last slice and held with q.
   always_ff @(posedge clk) begin
      if (rst) begin
         nz_r   <= 1'b0;
         zero_r <= 1'b0;
      end else if ((state == S_IDLE) && bus.start) begin
         nz_r <= 1'b0;
      end else if (state == S_RUN) begin
         nz_r <= nz_r | (|alu_q);
         if (last) zero_r <= ~(nz_r | (|alu_q));
      end
   end
`endif

   // Operand latch on accept, then per-slice result write-back and carry chaining.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         q_r     <= '0;
         op_r    <= 4'h0;
         cin_r   <= 1'b0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         idx     <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         a_r   <= bus.a;
         b_r   <= bus.b;
         op_r  <= bus.op;
         cin_r <= bus.cin;
         idx   <= (bus.op[3:2] == OPC_SHR) ? IDX_LAST : '0;
      end else if (state == S_RUN) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (idx == IW'(k)) q_r[k*8 +: 8] <= alu_q;
         end
         carry_r <= alu_cout;
         if (last) cout_r <= alu_cout;
         else      idx    <= shr_dir ? (idx - IW'(1)) : (idx + IW'(1));
      end
   end

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb/tb_alu_wide_seq.sv - self-checking bench for alu_wide_seq (NBYTES=4) with an 8-bit alu on alu_* ports
module tb_alu_wide_seq;

   logic        clk;
   logic        rst;
   logic [7:0]  alu_a, alu_b, alu_q;
   logic [3:0]  alu_op;
   logic        alu_cin, alu_cout;

   int total = 0;
   int bad   = 0;

   alu_wide_seq_if #(.NBYTES(4)) bus ();

   alu_wide_seq #(.NBYTES(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_q(alu_q), .alu_cout(alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 8-bit alu: 00 add/sub (op[1]=sub, op[0]=use cin), 01 and/or/xor/nor, 10 shl, 11 shr.
   logic [8:0] s9;
   always_comb begin
      s9       = 9'h000;
      alu_q    = 8'h00;
      alu_cout = 1'b0;
      case (alu_op[3:2])
         2'b00: begin
            if (!alu_op[1]) s9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_op[0] & alu_cin};
            else            s9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_op[0] & alu_cin};
            alu_q    = s9[7:0];
            alu_cout = s9[8];
         end
         2'b01: begin
            case (alu_op[1:0])
               2'b00: alu_q = alu_a & alu_b;
               2'b01: alu_q = alu_a | alu_b;
               2'b10: alu_q = alu_a ^ alu_b;
               default: alu_q = ~(alu_a | alu_b);
            endcase
         end
         2'b10: {alu_cout, alu_q} = {alu_a, alu_cin};
         default: {alu_q, alu_cout} = {alu_cin, alu_a};
      endcase
   end

   // Whole-word reference: {cout, q}.
   function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin);
      logic [32:0] r;
      logic        c;
      c = op[0] & cin;
      r = '0;
      case (op[3:2])
         2'b00: r = op[1] ? ({1'b0, a} - {1'b0, b} - {32'h0, c}) : ({1'b0, a} + {1'b0, b} + {32'h0, c});
         2'b01: begin
            case (op[1:0])
               2'b00: r = {1'b0, a & b};
               2'b01: r = {1'b0, a | b};
               2'b10: r = {1'b0, a ^ b};
               default: r = {1'b0, ~(a | b)};
            endcase
         end
         2'b10: r = {a[31], a[30:0], cin};
         default: r = {a[0], cin, a[31:1]};
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Compare process: every cycle after reset, outputs are checked against the word model.
   logic [32:0] exp_q[$];
   int          acc_q[$];
   logic        armed = 1'b0;
   logic [31:0] hold_q;
   logic        hold_c;
   logic        hold_z;
   int          cyc = 0;
   always @(negedge clk) begin
      logic [32:0] e;
      int          ac;
      cyc++;
      if (armed) begin
         if (bus.done) begin
            if (exp_q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               chk("m_q", bus.q, e[31:0]);
               chk("m_cout", bus.cout, e[32]);
               chk("m_latency", cyc - ac, 5);
               chk("m_busy_in_done", bus.busy, 1);
`ifdef ALU_WIDE_SEQ_ZERO_EN
               chk("m_zero", bus.zero, e[31:0] == 32'h0);
               hold_z = (e[31:0] == 32'h0);
`endif
               hold_q = e[31:0];
               hold_c = e[32];
            end
            chk("m_alu_idle_done", {alu_a, alu_b, alu_op, alu_cin}, 0);
         end else if (!bus.busy) begin
            chk("m_idle_q", bus.q, hold_q);
            chk("m_idle_cout", bus.cout, hold_c);
            chk("m_alu_idle", {alu_a, alu_b, alu_op, alu_cin}, 0);
`ifdef ALU_WIDE_SEQ_ZERO_EN
            chk("m_idle_zero", bus.zero, hold_z);
`endif
            if (exp_q.size() != 0) begin
               chk("m_not_started", 0, 1);
               exp_q.delete();
               acc_q.delete();
            end
         end else begin
            if (exp_q.size() == 0) chk("m_spurious_busy", 1, 0);
            else if (cyc - acc_q[0] > 5) begin
               chk("m_timeout", 0, 1);
               exp_q.delete();
               acc_q.delete();
            end
         end
      end
      if (rst) begin
         armed  = 1'b1;
         exp_q.delete();
         acc_q.delete();
         hold_q = 32'h0;
         hold_c = 1'b0;
         hold_z = 1'b0;
      end else if (armed && bus.start && !bus.busy) begin
         exp_q.push_back(model(bus.op, bus.a, bus.b, bus.cin));
         acc_q.push_back(cyc);
      end
   end

   int          lat;
   logic        got;
   logic [31:0] seq_a;
   logic [3:0]  seq_cin;
   logic [15:0] seq_op;

   // Issue one op from an idle DUT, record slice traffic, return one cycle after done.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
      bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      seq_a = '0; seq_cin = '0; seq_op = '0; lat = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (bus.done) got = 1'b1;
         else if (bus.busy) begin
            seq_a   = {seq_a[23:0], alu_a};
            seq_cin = {seq_cin[2:0], alu_cin};
            seq_op  = {seq_op[11:0], alu_op};
         end
      end
      if (!got) chk("done_wait", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic run_chk(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] eq, input logic ec);
      run_op(op, a, b, cin);
      chk({nm, "_q"}, bus.q, eq);
      chk({nm, "_cout"}, bus.cout, ec);
   endtask

   int          n_acc, n_done;
   logic [31:0] dq[2];

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 4'h0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_q", bus.q, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      run_chk("t1", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
      chk("t1_latency", lat, 5);
      chk("t1_op_seq", seq_op, 16'h0111);
      chk("t1_cin_seq", seq_cin, 4'b0111);
`ifdef ALU_WIDE_SEQ_ZERO_EN
      chk("t1_zero", bus.zero, 1);
`endif
      run_chk("t2", 4'b0010, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0);
      chk("t2_op_seq", seq_op, 16'h2333);
      chk("t2_cin_seq", seq_cin, 4'b0110);
`ifdef ALU_WIDE_SEQ_ZERO_EN
      chk("t2_zero", bus.zero, 0);
`endif
      run_chk("adc", 4'b0001, 32'h000000FF, 32'h00000000, 1'b1, 32'h00000100, 1'b0);
      run_chk("add_nocin", 4'b0000, 32'h00000001, 32'h00000001, 1'b1, 32'h00000002, 1'b0);
      run_chk("sbc", 4'b0011, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1);
      run_chk("and", 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 1'b0);
      run_chk("or",  4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hFFF0FFF0, 1'b0);
      run_chk("xor", 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h0FF00FF0, 1'b0);
      run_chk("nor", 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'h000F000F, 1'b0);
      run_chk("shl", 4'b1000, 32'h00000080, 32'h0, 1'b0, 32'h00000100, 1'b0);
      chk("shl_a_seq", seq_a, 32'h80000000);
      chk("shl_cin_seq", seq_cin, 4'b0100);
      run_chk("shr", 4'b1100, 32'h01000000, 32'h0, 1'b0, 32'h00800000, 1'b0);
      chk("shr_a_seq", seq_a, 32'h01000000);
      chk("shr_cin_seq", seq_cin, 4'b0100);
      run_chk("shl_edge", 4'b1000, 32'h80000000, 32'h0, 1'b1, 32'h00000001, 1'b1);
      run_chk("shr_edge", 4'b1100, 32'h00000001, 32'h0, 1'b1, 32'h80000000, 1'b1);

      // start held high for 10 cycles while operand A keeps changing
      bus.op = 4'b0000; bus.a = 32'h11111111; bus.b = 32'h22222222; bus.cin = 1'b0; bus.start = 1'b1;
      n_acc = 0; n_done = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i < 10 && bus.start && !bus.busy) n_acc++;
         if (bus.done) begin
            if (n_done < 2) dq[n_done] = bus.q;
            n_done++;
         end
         @(posedge clk);
         #1;
         if (i < 9) bus.a = bus.a + 32'h01010101;
         else       bus.start = 1'b0;
      end
      chk("hold_accepts", n_acc, 2);
      chk("hold_dones", n_done, 2);
      chk("hold_q0", dq[0], 32'h33333333);
      chk("hold_q1", dq[1], 32'h39393939);

      // reset during RUN slice 2
      bus.op = 4'b0000; bus.a = 32'h01020304; bus.b = 32'h10101010; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_q", bus.q, 0);
      chk("abort_cout", bus.cout, 0);
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      @(posedge clk);
      #1;
      run_chk("fresh", 4'b0000, 32'h01020304, 32'h10101010, 1'b0, 32'h11121314, 1'b0);
      chk("fresh_latency", lat, 5);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
